// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, fixed WIDTH-cycle latency.
// Signed mode weights the multiplier MSB negatively, so the last iteration subtracts.
module mult_seq #(
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               sgn,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             r_state, w_next;
  logic [2*WIDTH-1:0] r_mcand, r_acc, r_out;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_sgn;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept, w_last;
  logic [2*WIDTH-1:0] w_ext1, w_acc_nxt;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_cnt == CNT_W'(1));
  assign w_ext1   = sgn ? {{WIDTH{in1[WIDTH-1]}}, in1} : {{WIDTH{1'b0}}, in1};

  // Multiplicand is pre-extended to 2*WIDTH, so the add/sub wraps to the exact product.
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_mplier[0])
      w_acc_nxt = (w_last && r_sgn) ? r_acc - r_mcand : r_acc + r_mcand;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = BUSY;
      BUSY:    if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_sgn    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
    end else if (w_accept) begin
      r_mcand  <= w_ext1;
      r_mplier <= in2;
      r_sgn    <= sgn;
      r_acc    <= '0;
      r_cnt    <= CNT_W'(WIDTH);
    end else if (r_state == BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt - CNT_W'(1);
      if (w_last) r_out <= w_acc_nxt;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: WIDTH=5 vector table and corner sequences, plus WIDTH 2/8/16 random sweeps.
module tb_mult_seq;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in1, in2;
  logic           sgn, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2*W-1:0] out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sbq[$];

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .sgn(sgn),
    .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input bit s);
    longint m, sa, sb, p;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (s && sa[w-1]) sa = sa - (longint'(1) << w);
    if (s && sb[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p & ((longint'(1) << (2*w)) - 1));
  endfunction

  typedef struct {
    logic [W-1:0]   a, b;
    bit             s;
    logic [2*W-1:0] exp;
  } vec_t;

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input logic [2*W-1:0] e);
    int lat;
    in1 = a; in2 = b; sgn = s; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sbq.push_back(64'(e));
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'(W));
    chk("product", 64'(out), sbq.pop_front());
    @(posedge clk); #1;
    chk("valid_one_cycle", 64'(out_valid), 64'(0));
    chk("ready_after_done", 64'(in_ready), 64'(1));
  endtask

  // Independent wider/narrower instances run their random sweeps concurrently.
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int SW = (g == 0) ? 2 : (g == 1) ? 8 : 16;
    logic            rst_s, s_s, iv_s, rdy_s, ov_s, ordy_s, bsy_s;
    logic [SW-1:0]   a_s, b_s;
    logic [2*SW-1:0] p_s;
    logic [63:0]     q[$];
    bit              done = 1'b0;

    mult_seq #(.WIDTH(SW)) u_sw (
      .clk(clk), .rst(rst_s), .in1(a_s), .in2(b_s), .sgn(s_s),
      .in_valid(iv_s), .in_ready(rdy_s), .out(p_s),
      .out_valid(ov_s), .out_ready(ordy_s), .busy(bsy_s)
    );

    initial begin
      int cyc, nres, acc_e;
      bit tog;
      rst_s = 1'b1; a_s = '0; b_s = '0; s_s = 1'b0; iv_s = 1'b0; ordy_s = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_s = 1'b0;
      iv_s = 1'b1; cyc = 0; nres = 0; acc_e = 0; tog = 1'b0;
      while (nres < 2000 && cyc < 60000) begin
        a_s = SW'($urandom);
        b_s = SW'($urandom);
        if (rdy_s) begin
          s_s = tog; tog = ~tog;
          q.push_back(ref_mul(SW, 32'(a_s), 32'(b_s), s_s));
          acc_e = cyc + 1;
        end else begin
          s_s = 1'($urandom);
        end
        @(posedge clk); #1;
        cyc++;
        if (ov_s) begin
          chk($sformatf("sweep%0d_prod", SW), 64'(p_s), q.pop_front());
          chk($sformatf("sweep%0d_lat", SW), 64'(cyc - acc_e), 64'(SW));
          nres++;
        end
      end
      chk($sformatf("sweep%0d_count", SW), 64'(nres), 64'(2000));
      done = 1'b1;
    end
  end

  initial begin
    vec_t vt[12];
    logic [2*W-1:0] held;
    int lat, bad, cyc, last, nres, guard;

    vt[0]  = '{a: 5'd31, b: 5'd31, s: 1'b0, exp: 10'h3C1};
    vt[1]  = '{a: 5'd16, b: 5'd16, s: 1'b1, exp: 10'h100};
    vt[2]  = '{a: 5'd16, b: 5'd15, s: 1'b1, exp: 10'h310};
    vt[3]  = '{a: 5'd0,  b: 5'd27, s: 1'b0, exp: 10'd0};
    vt[4]  = '{a: 5'd7,  b: 5'd3,  s: 1'b0, exp: 10'd21};
    vt[5]  = '{a: 5'd31, b: 5'd31, s: 1'b1, exp: 10'd1};
    vt[6]  = '{a: 5'd31, b: 5'd1,  s: 1'b1, exp: 10'h3FF};
    vt[7]  = '{a: 5'd31, b: 5'd1,  s: 1'b0, exp: 10'd31};
    vt[8]  = '{a: 5'd15, b: 5'd15, s: 1'b1, exp: 10'd225};
    vt[9]  = '{a: 5'd16, b: 5'd1,  s: 1'b1, exp: 10'h3F0};
    vt[10] = '{a: 5'd16, b: 5'd31, s: 1'b1, exp: 10'd16};
    vt[11] = '{a: 5'd21, b: 5'd19, s: 1'b0, exp: 10'd399};

    rst = 1'b1; in1 = '0; in2 = '0; sgn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vt[i]) run_op(vt[i].a, vt[i].b, vt[i].s, vt[i].exp);

    // Idle with no request: product held, out_ready ignored
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'(i);
      @(posedge clk); #1;
      chk("idle_hold", {out_valid, in_ready, busy, 54'd0, out}, {3'b010, 54'd0, 10'd399});
    end

    // Backpressure in DONE
    in1 = 5'd3; in2 = 5'd9; sgn = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", 64'(lat), 64'(W));
    held = out;
    chk("bp_product", 64'(held), 64'(27));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); in1 = W'($urandom); in2 = W'($urandom);
      @(posedge clk); #1;
      chk("bp_stable", {out_valid, in_ready, busy, 54'd0, out}, {3'b101, 54'd0, 10'd27});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {out_valid, in_ready, busy, 54'd0, out}, {3'b010, 54'd0, 10'd27});

    // Reset in the middle of an operation
    in1 = 5'd31; in2 = 5'd31; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out", 64'(out), 64'(0));
    chk("midrst_flags", {out_valid, in_ready, busy}, 3'b010);
    @(negedge clk) rst = 1'b0;
    bad = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) bad++; end
    chk("midrst_no_spurious", 64'(bad), 64'(0));
    in1 = 5'd2; in2 = 5'd3; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("first_accept", 64'(busy), 64'(1));
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("post_rst_product", 64'(out), 64'(6));
    @(posedge clk); #1;

    // Back-to-back stream, operands churning every cycle
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; last = -1; nres = 0;
    while (nres < 30 && cyc < 1000) begin
      in1 = W'($urandom); in2 = W'($urandom); sgn = 1'($urandom);
      if (in_ready) sbq.push_back(ref_mul(W, 32'(in1), 32'(in2), sgn));
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        chk("b2b_product", 64'(out), sbq.pop_front());
        if (last >= 0) chk("b2b_interval", 64'(cyc - last), 64'(W + 2));
        last = cyc; nres++;
      end
    end
    chk("b2b_count", 64'(nres), 64'(30));
    in_valid = 1'b0;

    guard = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && guard < 80000) begin
      @(posedge clk); guard++;
    end
    chk("sweeps_done", {61'd0, g_sw[0].done, g_sw[1].done, g_sw[2].done}, 64'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 5, operand width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH+1), iteration counter width; it is derived and never overridden.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port in1, input, WIDTH, multiplicand.
REQ-006 The block SHALL have port in2, input, WIDTH, multiplier.
REQ-007 The block SHALL have port sgn, input, 1, operand mode: 1 = two's-complement signed, 0 = unsigned; sampled with the operands.
REQ-008 The block SHALL have port in_valid, input, 1, operands present.
REQ-009 The block SHALL have port in_ready, output, 1, block able to accept operands.
REQ-010 The block SHALL have port out, output, 2*WIDTH, product.
REQ-011 The block SHALL have port out_valid, output, 1, product valid.
REQ-012 The block SHALL have port out_ready, input, 1, consumer accepts product.
REQ-013 The block SHALL have port busy, output, 1, high in BUSY or DONE.

Function
REQ-014 The block SHALL implement FSM states IDLE, BUSY, DONE; reset state is IDLE.
REQ-015 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE); busy SHALL equal (state!=IDLE); all are decoded from registered state.
REQ-016 IDLE->BUSY: at a clk edge with in_valid && in_ready, the block SHALL register in1, in2 and sgn, clear the accumulator, and load the iteration counter with WIDTH.
REQ-017 IDLE with in_valid=0: the block SHALL hold state, and out SHALL keep its last value.
REQ-018 BUSY: each edge SHALL perform one shift-add iteration and decrement the counter; BUSY->DONE SHALL occur on the edge where the counter reaches 0, i.e. exactly WIDTH edges after acceptance.
REQ-019 Latency SHALL be fixed: with acceptance at edge E0, out_valid first SHALL be high in the cycle after edge E0+WIDTH, independent of operand values and of sgn.
REQ-020 DONE: out and out_valid SHALL be held stable until an edge with out_ready=1, after which the state SHALL be IDLE; out SHALL retain the product afterwards.
REQ-021 There SHALL be no overlap: a new operand pair is accepted only in IDLE, so the minimum issue interval is WIDTH+2 cycles when out_ready is tied high.
REQ-022 in1/in2/sgn/in_valid changes during BUSY or DONE SHALL be ignored.
REQ-023 Arithmetic, sgn=0: out SHALL equal in1*in2, zero-extended, exact in 2*WIDTH bits.
REQ-024 Arithmetic, sgn=1: out SHALL equal the two's-complement product in 2*WIDTH bits, exact for all inputs including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = +2^(2*WIDTH-2).
REQ-025 No overflow is possible; the block SHALL have no saturation or flag.
REQ-026 out_ready asserted in IDLE or BUSY SHALL have no effect.

Reset
REQ-027 rst=1 SHALL asynchronously force state=IDLE, out=0, the operand registers, accumulator and counter to 0, in_ready=1 (combinational from state), out_valid=0 and busy=0.
REQ-028 Reset mid-BUSY or mid-DONE SHALL discard the transaction; no out_valid pulse SHALL follow reset release.
REQ-029 After rst deasserts, the first accepting edge SHALL be the first rising clk edge with in_valid=1.

Verification (WIDTH=5)
REQ-030 Unsigned max: in1=31, in2=31, sgn=0, out_ready=1 -> out=10'h3C1 (961), out_valid high exactly in the cycle after edge E0+5, for one cycle.
REQ-031 Signed corner: in1=5'b10000, in2=5'b10000, sgn=1 -> out=10'h100 (+256); in1=5'b10000, in2=5'b01111, sgn=1 -> out=10'h310 (-240).
REQ-032 Backpressure: out_ready=0 for 10 cycles in DONE -> out and out_valid stable; in_ready=0 and in_valid pulses are ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-033 Reset mid-op: assert rst at iteration 3 -> same cycle out=0, out_valid=0, in_ready=1; after release, no spurious out_valid.
REQ-034 Back-to-back: in_valid held high, out_ready=1, random operand stream -> one result every 7 cycles, each result matching the reference model for both sgn values.
REQ-035 Parameter sweep: WIDTH in {2,8,16} with 1000 random operand pairs per mode -> all products exact and latency equal to WIDTH.
